// File: rtl/score_event_sequencer.sv
// -----------------------------------------------------------------------------
// score_event_sequencer
//
// Turns the level-type collision signals from the collision detector into
// exactly one scoring event per contiguous overlap episode. It queues the
// events and hands them to the score bitmap/counter block as single-cycle
// pulses. Gold and diamond pulses never coincide, and every pulse is followed
// by a fixed idle gap, so the downstream adders never see two increments in
// the same cycle or in adjacent cycles.
//
// Optional feature (compile-time macro SCORE_EVT_STREAK_EN):
//   When the macro is defined, a 3-bit streak counter counts diamond events
//   accepted into the queue. An accepted gold event or game_active low clears
//   it. On every 8th consecutive diamond the counter wraps from 7 to 0 and
//   that diamond enqueues 3 increments instead of 1. Each of those increments
//   is subject to saturation.
//   When the macro is undefined, no streak logic exists and every diamond
//   enqueues exactly one event.
//
// Parameters:
//   DEPTH      - saturation value of each pending-event counter
//   GAP_CYCLES - idle cycles forced after every emitted pulse (legal range 1..15)
//
// Ports:
//   clk               in  system clock
//   resetN            in  synchronous active-low reset
//   startOfFrame      in  one-cycle pulse at the start of each video frame
//   game_active       in  gameplay running; low ignores collisions, flushes queue
//   collision_gold    in  level: digger overlaps a gold bag this cycle
//   collision_dimond  in  level: digger overlaps a diamond this cycle
//   player_eat_gold   out one-cycle pulse, add a gold score
//   player_eat_dimond out one-cycle pulse, add a diamond score
//   queue_overflow    out sticky, an event was dropped at saturation
//   busy              out events pending or emission/gap in progress
// -----------------------------------------------------------------------------
module score_event_sequencer #(
  parameter int DEPTH      = 7,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic game_active,
  input  logic collision_gold,
  input  logic collision_dimond,
  output logic player_eat_gold,
  output logic player_eat_dimond,
  output logic queue_overflow,
  output logic busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // Two extra bits hold a full counter plus up to three increments at once.
  localparam int SUM_W = CNT_W + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  // Adds inc, removes dec (only if there is something to remove) and clamps
  // the result at DEPTH. The MSB of the result flags that increments were
  // dropped. An increment and a decrement in the same cycle cancel, so a
  // counter sitting at DEPTH is not treated as an overflow in that case.
  function automatic logic [CNT_W:0] sat_update(
    input logic [CNT_W-1:0] cnt,
    input logic [1:0]       inc,
    input logic             dec
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    if (dec && (cnt != '0)) begin
      sum = sum - SUM_W'(1);
    end
    if (sum > SUM_W'(DEPTH)) begin
      return {1'b1, CNT_W'(DEPTH)};
    end
    return {1'b0, sum[CNT_W-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             gold_hit_cur_q,   gold_hit_cur_d;
  logic             dimond_hit_cur_q, dimond_hit_cur_d;
  logic             gold_hit_prev_q,  gold_hit_prev_d;
  logic             dimond_hit_prev_q, dimond_hit_prev_d;
  logic [CNT_W-1:0] gold_pending_q,   gold_pending_d;
  logic [CNT_W-1:0] dimond_pending_q, dimond_pending_d;
  logic [1:0]       state_q,          state_d;
  logic             sel_dimond_q,     sel_dimond_d;
  logic             last_dimond_q,    last_dimond_d;
  logic [3:0]       gap_q,            gap_d;
  logic             queue_overflow_q, queue_overflow_d;
`ifdef SCORE_EVT_STREAK_EN
  logic [2:0]       streak_q,         streak_d;
`endif

  // Intermediate combinational terms
  logic             new_gold;
  logic             new_dimond;
  logic [1:0]       dimond_inc;
  logic             gold_dec;
  logic             dimond_dec;
  logic             gold_ovf;
  logic             dimond_ovf;
  logic [CNT_W-1:0] gold_upd;
  logic [CNT_W-1:0] dimond_upd;

  // ---------------------------------------------------------------------------
  // Frame capture and evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    gold_hit_cur_d    = gold_hit_cur_q;
    dimond_hit_cur_d  = dimond_hit_cur_q;
    gold_hit_prev_d   = gold_hit_prev_q;
    dimond_hit_prev_d = dimond_hit_prev_q;
    new_gold          = 1'b0;
    new_dimond        = 1'b0;

    if (!game_active) begin
      gold_hit_cur_d    = 1'b0;
      dimond_hit_cur_d  = 1'b0;
      gold_hit_prev_d   = 1'b0;
      dimond_hit_prev_d = 1'b0;
    end else if (startOfFrame) begin
      // Rising edge of the per-frame hit flag marks a new overlap episode.
      new_gold          = gold_hit_cur_q & ~gold_hit_prev_q;
      new_dimond        = dimond_hit_cur_q & ~dimond_hit_prev_q;
      gold_hit_prev_d   = gold_hit_cur_q;
      dimond_hit_prev_d = dimond_hit_cur_q;
      // A collision on the startOfFrame cycle belongs to the new frame.
      gold_hit_cur_d    = collision_gold;
      dimond_hit_cur_d  = collision_dimond;
    end else begin
      gold_hit_cur_d    = gold_hit_cur_q | collision_gold;
      dimond_hit_cur_d  = dimond_hit_cur_q | collision_dimond;
    end
  end

  // ---------------------------------------------------------------------------
  // Diamond enqueue amount
  // ---------------------------------------------------------------------------
`ifdef SCORE_EVT_STREAK_EN
  always_comb begin
    streak_d   = streak_q;
    dimond_inc = {1'b0, new_dimond};
    if (!game_active) begin
      streak_d = 3'd0;
    end else if (new_gold) begin
      // A gold event breaks the streak. A diamond in the same frame starts
      // a new streak of length one.
      streak_d = {2'b00, new_dimond};
    end else if (new_dimond) begin
      if (streak_q == 3'd7) begin
        streak_d   = 3'd0;
        dimond_inc = 2'd3;
      end else begin
        streak_d = streak_q + 3'd1;
      end
    end
  end
`else
  always_comb begin
    dimond_inc = {1'b0, new_dimond};
  end
`endif

  // ---------------------------------------------------------------------------
  // Emission FSM: IDLE -> EMIT (1 cycle) -> GAP (GAP_CYCLES cycles) -> IDLE
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sel_dimond_d  = sel_dimond_q;
    last_dimond_d = last_dimond_q;
    gap_d         = gap_q;
    gold_dec      = 1'b0;
    dimond_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Pending events are about to be flushed while game_active is low,
        // so no new emission may start then.
        if (game_active && ((gold_pending_q != '0) || (dimond_pending_q != '0))) begin
          if ((gold_pending_q != '0) && (dimond_pending_q != '0)) begin
            sel_dimond_d = ~last_dimond_q;
          end else begin
            sel_dimond_d = (dimond_pending_q != '0);
          end
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        gold_dec      = ~sel_dimond_q;
        dimond_dec    = sel_dimond_q;
        last_dimond_d = sel_dimond_q;
        gap_d         = GAP_LOAD;
        state_d       = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending counters and overflow flag
  // ---------------------------------------------------------------------------
  always_comb begin
    {gold_ovf, gold_upd}     = sat_update(gold_pending_q, {1'b0, new_gold}, gold_dec);
    {dimond_ovf, dimond_upd} = sat_update(dimond_pending_q, dimond_inc, dimond_dec);

    gold_pending_d   = gold_upd;
    dimond_pending_d = dimond_upd;
    queue_overflow_d = queue_overflow_q;

    if (!game_active) begin
      gold_pending_d   = '0;
      dimond_pending_d = '0;
    end else begin
      queue_overflow_d = queue_overflow_q | gold_ovf | dimond_ovf;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetN) begin
      gold_hit_cur_q    <= 1'b0;
      dimond_hit_cur_q  <= 1'b0;
      gold_hit_prev_q   <= 1'b0;
      dimond_hit_prev_q <= 1'b0;
      gold_pending_q    <= '0;
      dimond_pending_q  <= '0;
      state_q           <= ST_IDLE;
      sel_dimond_q      <= 1'b0;
      last_dimond_q     <= 1'b0;   // gold counts as last sent, so diamond wins first
      gap_q             <= 4'd0;
      queue_overflow_q  <= 1'b0;
    end else begin
      gold_hit_cur_q    <= gold_hit_cur_d;
      dimond_hit_cur_q  <= dimond_hit_cur_d;
      gold_hit_prev_q   <= gold_hit_prev_d;
      dimond_hit_prev_q <= dimond_hit_prev_d;
      gold_pending_q    <= gold_pending_d;
      dimond_pending_q  <= dimond_pending_d;
      state_q           <= state_d;
      sel_dimond_q      <= sel_dimond_d;
      last_dimond_q     <= last_dimond_d;
      gap_q             <= gap_d;
      queue_overflow_q  <= queue_overflow_d;
    end
  end

`ifdef SCORE_EVT_STREAK_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      streak_q <= 3'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they are one clean cycle
  // wide and can never be high together.
  // ---------------------------------------------------------------------------
  assign player_eat_gold   = (state_q == ST_EMIT) & ~sel_dimond_q;
  assign player_eat_dimond = (state_q == ST_EMIT) &  sel_dimond_q;
  assign queue_overflow    = queue_overflow_q;
  assign busy              = (state_q != ST_IDLE) | (gold_pending_q != '0) |
                             (dimond_pending_q != '0);

endmodule

// File: tb/tb_score_event_sequencer.sv
module tb_score_event_sequencer;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  logic game_active;
  logic collision_gold;
  logic collision_dimond;
  logic player_eat_gold;
  logic player_eat_dimond;
  logic queue_overflow;
  logic busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gold_pulses = 0;
  int dimond_pulses = 0;
  int last_gold_cyc = -1;
  int both_high = 0;

  score_event_sequencer #(.DEPTH(7), .GAP_CYCLES(2)) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .game_active       (game_active),
    .collision_gold    (collision_gold),
    .collision_dimond  (collision_dimond),
    .player_eat_gold   (player_eat_gold),
    .player_eat_dimond (player_eat_dimond),
    .queue_overflow    (queue_overflow),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (player_eat_gold) begin
      gold_pulses++;
      last_gold_cyc = cyc;
    end
    if (player_eat_dimond) dimond_pulses++;
    if (player_eat_gold && player_eat_dimond) both_high++;
  end

  typedef struct packed {
    logic sof;
    logic ga;
    logic cg;
    logic cd;
    logic eg;
    logic ed;
    logic eb;
  } vec_t;

  vec_t tbl [15];

  task automatic drive(input logic sof, input logic ga, input logic cg, input logic cd);
    startOfFrame     = sof;
    game_active      = ga;
    collision_gold   = cg;
    collision_dimond = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int len, input logic cg, input logic cd);
    for (int i = 0; i < len; i++) begin
      drive(i == 0, 1'b1, cg, cd);
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, s2;

    // sof ga cg cd | gold dimond busy
    tbl[0]  = 7'b1111_000;
    tbl[1]  = 7'b0111_000;
    tbl[2]  = 7'b0100_000;
    tbl[3]  = 7'b0100_000;
    tbl[4]  = 7'b1100_000;
    tbl[5]  = 7'b0100_001;
    tbl[6]  = 7'b0100_011;
    tbl[7]  = 7'b0100_001;
    tbl[8]  = 7'b1100_001;
    tbl[9]  = 7'b0100_001;
    tbl[10] = 7'b0100_101;
    tbl[11] = 7'b0100_001;
    tbl[12] = 7'b1100_001;
    tbl[13] = 7'b0100_000;
    tbl[14] = 7'b0100_000;

    // Reset state
    resetN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("rst_gold", player_eat_gold, 0);
    check("rst_dimond", player_eat_dimond, 0);
    check("rst_overflow", queue_overflow, 0);
    check("rst_busy", busy, 0);
    resetN = 1'b1;

    // Gold held for three whole frames gives a single pulse
    g0 = gold_pulses; d0 = dimond_pulses;
    run_frame(8, 1'b1, 1'b0);
    s2 = cyc;
    run_frame(8, 1'b1, 1'b0);
    run_frame(8, 1'b1, 1'b0);
    run_frame(8, 1'b0, 1'b0);
    run_frame(8, 1'b0, 1'b0);
    wait_idle(50, "hold_idle");
    check("hold_gold_count", gold_pulses - g0, 1);
    check("hold_dimond_count", dimond_pulses - d0, 0);
    check("hold_latency", last_gold_cyc - s2, 2);

    // Gold and diamond in the same frame, cycle by cycle
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].sof, tbl[i].ga, tbl[i].cg, tbl[i].cd);
      checks++;
      if ({player_eat_gold, player_eat_dimond, busy} !== {tbl[i].eg, tbl[i].ed, tbl[i].eb}) begin
        errors++;
        $display("FAIL vec%0d: gold/dimond/busy got %b%b%b, required %b%b%b", i,
                 player_eat_gold, player_eat_dimond, busy, tbl[i].eg, tbl[i].ed, tbl[i].eb);
      end
      tick();
    end

    // Saturation: 15 gold episodes on one-cycle frames, one is dropped
    g0 = gold_pulses;
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, 1'b1, (n < 30) && (n % 2 == 0), 1'b0);
      if (n == 29) check("ovf_before_drop", queue_overflow, 0);
      if (n == 30) check("ovf_after_drop", queue_overflow, 1);
      tick();
    end
    wait_idle(200, "sat_idle");
    check("sat_gold_count", gold_pulses - g0, 14);
    check("sat_overflow_sticky", queue_overflow, 1);

    // game_active drops during an EMIT with 4 diamonds pending
    g0 = gold_pulses; d0 = dimond_pulses;
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, n < 15, 1'b0, (n <= 14) && (n % 2 == 0));
      if (n == 15) check("flush_emit_pulse", player_eat_dimond, 1);
      if (n == 17) check("flush_gap_busy", busy, 1);
      if (n == 18) check("flush_idle_busy", busy, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) run_frame(6, 1'b0, 1'b0);
    check("flush_dimond_count", dimond_pulses - d0, 4);
    check("flush_gold_count", gold_pulses - g0, 0);

    // Reset during GAP with 3 golds pending
    g0 = gold_pulses;
    for (int n = 0; n <= 12; n++) begin
      drive(1'b1, 1'b1, (n <= 10) && (n % 2 == 0), 1'b0);
      if (n == 12) check("rgap_busy_before", busy, 1);
      resetN = (n == 12) ? 1'b0 : 1'b1;
      tick();
    end
    check("rgap_gold", player_eat_gold, 0);
    check("rgap_dimond", player_eat_dimond, 0);
    check("rgap_busy", busy, 0);
    check("rgap_overflow", queue_overflow, 0);
    resetN = 1'b1;
    for (int k = 0; k < 6; k++) run_frame(6, 1'b0, 1'b0);
    check("rgap_gold_count", gold_pulses - g0, 3);

    // Eight consecutive diamond episodes
    d0 = dimond_pulses;
    for (int k = 0; k < 8; k++) begin
      run_frame(4, 1'b0, 1'b1);
      run_frame(4, 1'b0, 1'b0);
    end
    wait_idle(200, "streak_idle");
`ifdef SCORE_EVT_STREAK_EN
    check("streak8_dimond_count", dimond_pulses - d0, 10);
`else
    check("streak8_dimond_count", dimond_pulses - d0, 8);
`endif

    // Same stimulus with a gold episode after the 4th diamond
    g0 = gold_pulses; d0 = dimond_pulses;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) run_frame(4, 1'b1, 1'b0);
      else        run_frame(4, 1'b0, 1'b1);
      run_frame(4, 1'b0, 1'b0);
    end
    wait_idle(200, "broken_idle");
    check("broken_dimond_count", dimond_pulses - d0, 8);
    check("broken_gold_count", gold_pulses - g0, 1);

    check("exclusive_outputs", both_high, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
